fetch_queue: RTL and testbench

- Fetch stage directly upstream of the decoder. It owns the program counter and drives the combinational instruction memory address.
- It captures each returned instruction word together with its PC into a small FIFO. Decode/dispatch drains the FIFO through a valid/ready handshake.
- Supports stall through back-pressure and full-queue flush on a redirect from branch resolution or exception handling.

---
 rtl/fetch_queue.sv | 103 ++++++++++
 tb/tb_fetch_queue.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, drives the instruction memory address and buffers
// {pc, inst} pairs in a small FIFO that decode drains via valid/ready.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [31:0]             imem_pc,
  input  logic [31:0]             imem_inst,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_pc,
  output logic [31:0]             out_inst,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [31:0]     pc_q, pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [31:0] mem_pc_q   [DEPTH];
  logic [31:0] mem_inst_q [DEPTH];

  logic pop, push;

  // Alignment bits of the redirect target are discarded by design.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Handshake events; a full queue may still accept a word when the head leaves.
  always_comb begin
    pop  = (count_q != '0) & out_ready;
    push = ~redirect_valid & ((count_q < Full) | pop);
  end

  // Next-state for PC, pointers and occupancy; redirect overrides push and pop.
  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[wr_ptr_q]   <= pc_q;
      mem_inst_q[wr_ptr_q] <= imem_inst;
    end
  end

  // Outputs come from registered state only; head is zeroed when empty.
  always_comb begin
    imem_pc   = pc_q;
    count     = count_q;
    out_valid = (count_q != '0);
    out_pc    = out_valid ? mem_pc_q[rd_ptr_q]   : 32'h0;
    out_inst  = out_valid ? mem_inst_q[rd_ptr_q] : 32'h0;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: table of directed vectors with expected
// count/imem_pc, plus a scoreboard queue tracking every pushed {pc, inst}.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [31:0]            imem_pc;
  logic [31:0]            imem_inst;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_pc;
  logic [31:0]            out_inst;
  logic [$clog2(DEPTH):0] count;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_pc        (imem_pc),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .count          (count)
  );

  always #5 clk = ~clk;

  // Instruction memory model: a distinct, non-zero word for every address.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  assign imem_inst = inst_of(imem_pc);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef struct {
    logic        rst;
    logic        rdv;
    logic [31:0] rpc;
    logic        rdy;
    int          cnt;
    logic [31:0] ipc;
  } vec_t;

  entry_t      sb[$];
  vec_t        vt[$];
  logic [31:0] m_pc;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic rst, input logic rdv, input logic [31:0] rpc,
                              input logic rdy, input int cnt, input logic [31:0] ipc);
    vec_t v;
    v = '{rst, rdv, rpc, rdy, cnt, ipc};
    vt.push_back(v);
  endfunction

  // One clock: drive inputs, predict push/pop, compare popped head before the
  // edge, then compare the whole visible state after the edge.
  task automatic step(input logic rst, input logic rdv, input logic [31:0] rpc,
                      input logic rdy, input logic use_tbl, input int exp_cnt,
                      input logic [31:0] exp_ipc);
    entry_t e;
    entry_t head;
    logic   pop, push;
    reset          = rst;
    redirect_valid = rdv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    pop  = (sb.size() != 0) && rdy;
    push = !rdv && ((sb.size() < int'(DEPTH)) || pop);
    if (rst) begin
      sb.delete();
      m_pc = RESET_PC;
    end else if (rdv) begin
      sb.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop) begin
        e = sb.pop_front();
        check("pop_pc", out_pc, e.pc);
        check("pop_inst", out_inst, e.inst);
      end
      if (push) begin
        e = '{m_pc, inst_of(m_pc)};
        sb.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    head = '{32'h0, 32'h0};
    if (sb.size() != 0) head = sb[0];
    check("count", 32'(count), 32'(sb.size()));
    check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    check("out_pc", out_pc, head.pc);
    check("out_inst", out_inst, head.inst);
    check("imem_pc", imem_pc, m_pc);
    if (use_tbl) begin
      check("tbl_count", 32'(count), 32'(exp_cnt));
      check("tbl_imem_pc", imem_pc, exp_ipc);
    end
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    m_pc           = RESET_PC;

    // Fill while stalled, then full queue with a simultaneous pop.
    add(1, 0, 32'h0, 0, 0, 32'h0);
    add(0, 0, 32'h0, 0, 1, 32'h4);
    add(0, 0, 32'h0, 0, 2, 32'h8);
    add(0, 0, 32'h0, 0, 3, 32'hC);
    add(0, 0, 32'h0, 0, 4, 32'h10);
    add(0, 0, 32'h0, 0, 4, 32'h10);
    add(0, 0, 32'h0, 0, 4, 32'h10);
    add(0, 0, 32'h0, 1, 4, 32'h14);
    // Redirect flush at count=3 with out_ready high.
    add(1, 0, 32'h0, 0, 0, 32'h0);
    add(0, 0, 32'h0, 0, 1, 32'h4);
    add(0, 0, 32'h0, 0, 2, 32'h8);
    add(0, 0, 32'h0, 0, 3, 32'hC);
    add(0, 1, 32'h83, 1, 0, 32'h80);
    add(0, 0, 32'h0, 0, 1, 32'h84);
    // Streaming from reset.
    add(1, 0, 32'h0, 1, 0, 32'h0);
    add(0, 0, 32'h0, 1, 1, 32'h4);
    add(0, 0, 32'h0, 1, 1, 32'h8);
    add(0, 0, 32'h0, 1, 1, 32'hC);
    add(0, 0, 32'h0, 1, 1, 32'h10);
    // PC wrap.
    add(0, 1, 32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC);
    add(0, 0, 32'h0, 1, 1, 32'h0);
    add(0, 0, 32'h0, 1, 1, 32'h4);
    add(0, 0, 32'h0, 1, 1, 32'h8);
    // Back-to-back redirects: the last one wins.
    add(0, 1, 32'h100, 0, 0, 32'h100);
    add(0, 1, 32'h207, 1, 0, 32'h204);
    add(0, 0, 32'h0, 0, 1, 32'h208);
    // Reset together with redirect at count=2.
    add(1, 0, 32'h0, 0, 0, 32'h0);
    add(0, 0, 32'h0, 0, 1, 32'h4);
    add(0, 0, 32'h0, 0, 2, 32'h8);
    add(1, 1, 32'h40, 1, 0, 32'h0);

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].rst, vt[i].rdv, vt[i].rpc, vt[i].rdy, 1'b1, vt[i].cnt, vt[i].ipc);
    end

    // Random traffic checked by the scoreboard alone.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), $urandom,
           1'($urandom_range(0, 1)), 1'b0, 0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
